// File: rtl/bus_move_pkg.sv
// Shared types and helpers for the bus move sequencer.
// State encoding, default sizes and a one-hot decode helper.
package bus_move_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_TURN
    } state_e;

    localparam int NREG_DEF = 8;
    localparam int NREQ_DEF = 2;

    function automatic logic oh_bit(
        input int unsigned idx,
        input int unsigned pos
    );
        return idx == pos;
    endfunction

endpackage

// File: rtl/bus_move_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search begins at ptr and wraps; first asserted request wins.
module rr_arbiter
    import bus_move_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   c;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_move_ctrl.sv
// Shared-bus move sequencer: arbitrates requesters and sequences
// rd/wr strobes through drive, latch and turnaround cycles.
module bus_move_ctrl
    import bus_move_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    parameter  int NREQ = NREQ_DEF,
    localparam int AW   = $clog2(NREG),
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_src,
    input  logic [NREQ*AW-1:0] req_dst,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREG-1:0]    rd,
    output logic [NREG-1:0]    wr,
    output logic             done,
    output logic [IW-1:0]    done_id,
    output logic             busy
);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [NREG-1:0] rd_q, rd_d;
    logic [NREG-1:0] wr_q, wr_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready = (state_q == S_IDLE) ? gnt : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        src_d   = src_q;
        dst_d   = dst_q;
        unique case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    state_d = S_DRIVE;
                    id_d    = gnt_idx;
                    src_d   = req_src[int'(gnt_idx)*AW +: AW];
                    dst_d   = req_dst[int'(gnt_idx)*AW +: AW];
                end
            end
            S_DRIVE: state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_TURN;
                ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are computed from the next state so the outputs are registered.
    always_comb begin
        rd_d = '0;
        wr_d = '0;
        for (int i = 0; i < NREG; i++) begin
            rd_d[i] = (state_d == S_DRIVE || state_d == S_LATCH)
                      && oh_bit(32'(src_d), 32'(i));
            wr_d[i] = (state_d == S_LATCH) && oh_bit(32'(dst_d), 32'(i));
        end
        done_d    = (state_d == S_TURN);
        busy_d    = (state_d != S_IDLE);
        done_id_d = done_d ? id_d : done_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign rd      = rd_q;
    assign wr      = wr_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign busy    = busy_q;

endmodule
